// File: rtl/key_if.sv
// Key bus between the raw push-buttons and the conditioned level/press/repeat/step outputs.
interface key_if #(
   parameter int unsigned NUM_KEYS = 3
);
   logic [NUM_KEYS-1:0] key_n;
   logic [NUM_KEYS-1:0] key_level;
   logic [NUM_KEYS-1:0] key_press;
   logic [NUM_KEYS-1:0] key_repeat;
   logic [NUM_KEYS-1:0] key_step;

   modport master (
      output key_n,
      input  key_level,
      input  key_press,
      input  key_repeat,
      input  key_step
   );

   modport slave (
      input  key_n,
      output key_level,
      output key_press,
      output key_repeat,
      output key_step
   );
endinterface

// File: rtl/key_conditioner.sv
// Per-key synchroniser, debouncer and hold-to-auto-repeat generator for active-low push-buttons.
module key_conditioner #(
   parameter int unsigned NUM_KEYS        = 3,
   parameter int unsigned DEBOUNCE_CYCLES = 1000000,
   parameter int unsigned HOLD_CYCLES     = 25000000,
   parameter int unsigned REPEAT_CYCLES   = 5000000
) (
   input  logic clk,
   input  logic rst,
   key_if.slave keys
);
   localparam int unsigned MAX_DH     = (DEBOUNCE_CYCLES > HOLD_CYCLES) ? DEBOUNCE_CYCLES : HOLD_CYCLES;
   localparam int unsigned MAX_CYCLES = (MAX_DH > REPEAT_CYCLES) ? MAX_DH : REPEAT_CYCLES;
   localparam int unsigned CW         = $clog2(MAX_CYCLES) + 1;

   if (DEBOUNCE_CYCLES < 2 || HOLD_CYCLES < 2 || REPEAT_CYCLES < 2) begin : g_param_check
      $error("key_conditioner: DEBOUNCE/HOLD/REPEAT_CYCLES must all be >= 2");
   end

   typedef enum logic [2:0] {
      IDLE,
      DB_PRESS,
      PRESSED,
      REPEAT,
      DB_RELEASE
   } state_t;

   logic [NUM_KEYS-1:0] sync1;
   logic [NUM_KEYS-1:0] sync2;
   logic [NUM_KEYS-1:0] sample;
   logic [NUM_KEYS-1:0] level;
   logic [NUM_KEYS-1:0] press;
   logic [NUM_KEYS-1:0] rpt;
   logic [NUM_KEYS-1:0] step;
   state_t              state [NUM_KEYS];
   logic [CW-1:0]       count [NUM_KEYS];

   assign sample = ~sync2;

   // Two-flop synchroniser plus one FSM/counter per key; pulses default low every cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1 <= '1;
         sync2 <= '1;
         level <= '0;
         press <= '0;
         rpt   <= '0;
         step  <= '0;
         for (int i = 0; i < NUM_KEYS; i++) begin
            state[i] <= IDLE;
            count[i] <= '0;
         end
      end else begin
         sync1 <= keys.key_n;
         sync2 <= sync1;
         press <= '0;
         rpt   <= '0;
         step  <= '0;
         for (int i = 0; i < NUM_KEYS; i++) begin
            case (state[i])
               IDLE: begin
                  if (sample[i]) begin
                     state[i] <= DB_PRESS;
                     count[i] <= CW'(1);
                  end
               end
               DB_PRESS: begin
                  if (!sample[i]) begin
                     state[i] <= IDLE;
                     count[i] <= '0;
                  end else if (count[i] == CW'(DEBOUNCE_CYCLES)) begin
                     state[i] <= PRESSED;
                     count[i] <= '0;
                     level[i] <= 1'b1;
                     press[i] <= 1'b1;
                     step[i]  <= 1'b1;
                  end else begin
                     count[i] <= count[i] + CW'(1);
                  end
               end
               PRESSED: begin
                  if (!sample[i]) begin
                     state[i] <= DB_RELEASE;
                     count[i] <= CW'(1);
                  end else if (count[i] == CW'(HOLD_CYCLES - 1)) begin
                     state[i] <= REPEAT;
                     count[i] <= '0;
                     rpt[i]   <= 1'b1;
                     step[i]  <= 1'b1;
                  end else begin
                     count[i] <= count[i] + CW'(1);
                  end
               end
               REPEAT: begin
                  if (!sample[i]) begin
                     state[i] <= DB_RELEASE;
                     count[i] <= CW'(1);
                  end else if (count[i] == CW'(REPEAT_CYCLES - 1)) begin
                     count[i] <= '0;
                     rpt[i]   <= 1'b1;
                     step[i]  <= 1'b1;
                  end else begin
                     count[i] <= count[i] + CW'(1);
                  end
               end
               DB_RELEASE: begin
                  // A bounce back to pressed restarts the hold timer without a new press
                  if (sample[i]) begin
                     state[i] <= PRESSED;
                     count[i] <= '0;
                  end else if (count[i] == CW'(DEBOUNCE_CYCLES)) begin
                     state[i] <= IDLE;
                     count[i] <= '0;
                     level[i] <= 1'b0;
                  end else begin
                     count[i] <= count[i] + CW'(1);
                  end
               end
               default: begin
                  state[i] <= IDLE;
                  count[i] <= '0;
                  level[i] <= 1'b0;
               end
            endcase
         end
      end
   end

   assign keys.key_level  = level;
   assign keys.key_press  = press;
   assign keys.key_repeat = rpt;
   assign keys.key_step   = step;
endmodule

// File: tb/tb_key_conditioner.sv
// Table-driven bench for key_conditioner with DEBOUNCE=4, HOLD=10, REPEAT=3.
module tb_key_conditioner;
   localparam int unsigned NK = 3;

   typedef struct {
      int         cyc;
      logic       rst;
      logic [2:0] key_n;
      logic [2:0] level;
      logic [2:0] press;
      logic [2:0] rpt;
      logic [2:0] step;
   } vec_t;

   logic clk = 1'b0;
   logic rst;
   int   total = 0;
   int   bad   = 0;
   vec_t vecs[$];

   key_if #(.NUM_KEYS(NK)) kif ();

   key_conditioner #(
      .NUM_KEYS(NK),
      .DEBOUNCE_CYCLES(4),
      .HOLD_CYCLES(10),
      .REPEAT_CYCLES(3)
   ) dut (
      .clk(clk),
      .rst(rst),
      .keys(kif.slave)
   );

   always #5 clk = ~clk;

   function automatic void add(int c, logic r, logic [2:0] kn, logic [2:0] lvl,
                               logic [2:0] prs, logic [2:0] rp);
      vec_t v;
      v.cyc   = c;
      v.rst   = r;
      v.key_n = kn;
      v.level = lvl;
      v.press = prs;
      v.rpt   = rp;
      v.step  = prs | rp;
      vecs.push_back(v);
   endfunction

   task automatic chk(string name, int c, logic [2:0] got, logic [2:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s cyc=%0d got=%b want=%b", name, c, got, want);
      end
   endtask

   localparam int A = 2;
   localparam int B = 50;
   localparam int C = 88;
   localparam int END_CYC = C + 38;

   initial begin
      int         idx;
      logic [2:0] lvl_e, prs_e, rp_e, st_e;

      // Scenario A: key0 press/hold/repeat/release, key1 bounce rejected
      add(A-2, 1, 3'b111, 3'b000, 3'b000, 3'b000);
      add(A-1, 1, 3'b111, 3'b000, 3'b000, 3'b000);
      add(A+0, 0, 3'b110, 3'b000, 3'b000, 3'b000);
      add(A+2, 0, 3'b100, 3'b000, 3'b000, 3'b000);
      add(A+4, 0, 3'b110, 3'b000, 3'b000, 3'b000);
      add(A+5, 0, 3'b100, 3'b000, 3'b000, 3'b000);
      add(A+6, 0, 3'b100, 3'b001, 3'b001, 3'b000);
      add(A+8, 0, 3'b110, 3'b001, 3'b000, 3'b000);
      add(A+16, 0, 3'b110, 3'b001, 3'b000, 3'b001);
      add(A+19, 0, 3'b110, 3'b001, 3'b000, 3'b001);
      add(A+22, 0, 3'b110, 3'b001, 3'b000, 3'b001);
      add(A+25, 0, 3'b110, 3'b001, 3'b000, 3'b001);
      add(A+28, 0, 3'b110, 3'b001, 3'b000, 3'b001);
      add(A+30, 0, 3'b111, 3'b001, 3'b000, 3'b000);
      add(A+31, 0, 3'b111, 3'b001, 3'b000, 3'b001);
      add(A+36, 0, 3'b111, 3'b000, 3'b000, 3'b000);
      // Scenario B: keys 0 and 2 together, then a 2-cycle release glitch on key0
      add(B-2, 1, 3'b111, 3'b000, 3'b000, 3'b000);
      add(B-1, 1, 3'b111, 3'b000, 3'b000, 3'b000);
      add(B+0, 0, 3'b010, 3'b000, 3'b000, 3'b000);
      add(B+6, 0, 3'b010, 3'b101, 3'b101, 3'b000);
      add(B+12, 0, 3'b011, 3'b101, 3'b000, 3'b000);
      add(B+14, 0, 3'b010, 3'b101, 3'b000, 3'b000);
      add(B+16, 0, 3'b010, 3'b101, 3'b000, 3'b100);
      add(B+19, 0, 3'b010, 3'b101, 3'b000, 3'b100);
      add(B+22, 0, 3'b010, 3'b101, 3'b000, 3'b100);
      add(B+25, 0, 3'b010, 3'b101, 3'b000, 3'b100);
      add(B+26, 0, 3'b010, 3'b101, 3'b000, 3'b001);
      add(B+28, 0, 3'b010, 3'b101, 3'b000, 3'b100);
      add(B+29, 0, 3'b010, 3'b101, 3'b000, 3'b001);
      add(B+31, 0, 3'b010, 3'b101, 3'b000, 3'b100);
      add(B+32, 0, 3'b010, 3'b101, 3'b000, 3'b001);
      add(B+34, 0, 3'b010, 3'b101, 3'b000, 3'b100);
      add(B+35, 0, 3'b010, 3'b101, 3'b000, 3'b001);
      // Scenario C: key0 held through a one-cycle reset at rel edge 20
      add(C-2, 1, 3'b111, 3'b000, 3'b000, 3'b000);
      add(C-1, 1, 3'b111, 3'b000, 3'b000, 3'b000);
      add(C+0, 0, 3'b110, 3'b000, 3'b000, 3'b000);
      add(C+6, 0, 3'b110, 3'b001, 3'b001, 3'b000);
      add(C+16, 0, 3'b110, 3'b001, 3'b000, 3'b001);
      add(C+19, 0, 3'b110, 3'b001, 3'b000, 3'b001);
      add(C+20, 1, 3'b110, 3'b000, 3'b000, 3'b000);
      add(C+21, 0, 3'b110, 3'b000, 3'b000, 3'b000);
      add(C+27, 0, 3'b110, 3'b001, 3'b001, 3'b000);
      add(C+37, 0, 3'b110, 3'b001, 3'b000, 3'b001);

      rst       = 1'b1;
      kif.key_n = 3'b111;
      idx   = 0;
      lvl_e = 3'b000;
      for (int c = 0; c <= END_CYC; c++) begin
         prs_e = 3'b000;
         rp_e  = 3'b000;
         st_e  = 3'b000;
         if (idx < vecs.size() && vecs[idx].cyc == c) begin
            rst       = vecs[idx].rst;
            kif.key_n = vecs[idx].key_n;
            lvl_e     = vecs[idx].level;
            prs_e     = vecs[idx].press;
            rp_e      = vecs[idx].rpt;
            st_e      = vecs[idx].step;
            idx++;
         end
         @(posedge clk);
         #1;
         chk("level", c, kif.key_level, lvl_e);
         chk("press", c, kif.key_press, prs_e);
         chk("repeat", c, kif.key_repeat, rp_e);
         chk("step", c, kif.key_step, st_e);
      end

      // Reset in the middle of key1's press debounce restarts the debounce
      rst       = 1'b1;
      kif.key_n = 3'b111;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_level", -1, kif.key_level, 3'b000);
      chk("rst_step", -1, kif.key_step, 3'b000);
      rst       = 1'b0;
      kif.key_n = 3'b101;
      for (int k = 0; k <= 12; k++) begin
         rst = (k == 3);
         @(posedge clk);
         #1;
         if (k < 10) begin
            chk("mid_rst_press", k, kif.key_press, 3'b000);
         end else if (k == 10) begin
            chk("mid_rst_press", k, kif.key_press, 3'b010);
            chk("mid_rst_level", k, kif.key_level, 3'b010);
         end else begin
            chk("mid_rst_after", k, kif.key_step, 3'b000);
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
